grf_wb_arbiter: RTL

GRF_WB_ARBITER -- requirements
Module: grf_wb_arbiter

---
 rtl/grf_wb_arbiter_if.sv | 51 +++++
 rtl/grf_wb_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/grf_wb_arbiter_if.sv
// Bus bundle for grf_wb_arbiter: pipeline W-stage write request, MDU result
// handshake, MDU issue / D-stage hazard lookup, and the shared GRF write port.
//   slave  : arbiter side (consumes requests, drives GRF port and hazard info)
//   master : environment side (pipeline, MDU and decode stage)
// fifo_cnt is log2(DEPTH)+1 bits wide so it can represent a full FIFO.
interface grf_wb_arbiter_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // Pipeline W stage
    logic          p_we;
    logic [4:0]    p_a3;
    logic [31:0]   p_wd;
    logic [31:0]   p_pc;
    logic          p_hold;
    // MDU result handshake
    logic          m_valid;
    logic [4:0]    m_a3;
    logic [31:0]   m_wd;
    logic [31:0]   m_pc;
    logic          m_ready;
    // MDU issue and D-stage hazard lookup
    logic          iss_valid;
    logic [4:0]    iss_a3;
    logic [4:0]    rs_a;
    logic [4:0]    rt_a;
    logic          stall;
    // GRF write port
    logic          grf_we;
    logic [4:0]    grf_a3;
    logic [31:0]   grf_wd;
    logic [31:0]   grf_pc;
    logic [CW-1:0] fifo_cnt;

    modport slave (
        input  p_we, p_a3, p_wd, p_pc,
        input  m_valid, m_a3, m_wd, m_pc,
        input  iss_valid, iss_a3, rs_a, rt_a,
        output p_hold, m_ready, stall,
        output grf_we, grf_a3, grf_wd, grf_pc, fifo_cnt
    );

    modport master (
        output p_we, p_a3, p_wd, p_pc,
        output m_valid, m_a3, m_wd, m_pc,
        output iss_valid, iss_a3, rs_a, rt_a,
        input  p_hold, m_ready, stall,
        input  grf_we, grf_a3, grf_wd, grf_pc, fifo_cnt
    );
endinterface

// File: rtl/grf_wb_arbiter.sv
// GRF write-back arbiter: shares the single GRF write port between the
// pipeline W stage and a DEPTH-entry FIFO of MDU results. The pipeline has
// priority, but after STARVE_MAX consecutive pipeline wins with results
// waiting, the FIFO head is forced through and the pipeline is held.
// A pending scoreboard tracks registers with an MDU result still in flight
// and raises stall for dependent D-stage reads.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : asynchronous active-low reset
//   bus   : grf_wb_arbiter_if.slave (pipeline, MDU, issue/hazard, GRF port)
module grf_wb_arbiter #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input logic                 clk,
    input logic                 reset,
    grf_wb_arbiter_if.slave     bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [4:0]    r_fifo_a3 [DEPTH];
    logic [31:0]   r_fifo_wd [DEPTH];
    logic [31:0]   r_fifo_pc [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_starve;
    logic [31:0]   r_pending;

    logic          w_empty;
    logic          w_m_ready;
    logic          w_push;
    logic          w_fifo_win;
    logic          w_pop;
    logic [4:0]    w_head_a3;
    logic [31:0]   w_pending_d;

    assign w_empty    = (r_cnt == '0);
    assign w_m_ready  = (r_cnt < CW'(DEPTH));
    // Results for r0 complete the handshake but are never queued.
    assign w_push     = bus.m_valid & w_m_ready & (bus.m_a3 != 5'd0);
    assign w_fifo_win = (r_starve == SW'(STARVE_MAX)) | ~bus.p_we;
    assign w_pop      = w_fifo_win & ~w_empty;
    assign w_head_a3  = r_fifo_a3[r_rptr];

    assign bus.m_ready  = w_m_ready;
    assign bus.fifo_cnt = r_cnt;
    assign bus.stall    = r_pending[bus.rs_a] | r_pending[bus.rt_a]
                        | (bus.iss_valid & r_pending[bus.iss_a3]);

    always_comb begin
        bus.grf_we = 1'b0;
        bus.grf_a3 = 5'd0;
        bus.grf_wd = 32'd0;
        bus.grf_pc = 32'd0;
        bus.p_hold = 1'b0;
        if (w_pop) begin
            bus.grf_we = 1'b1;
            bus.grf_a3 = w_head_a3;
            bus.grf_wd = r_fifo_wd[r_rptr];
            bus.grf_pc = r_fifo_pc[r_rptr];
            bus.p_hold = bus.p_we;
        end else if (bus.p_we) begin
            bus.grf_we = 1'b1;
            bus.grf_a3 = bus.p_a3;
            bus.grf_wd = bus.p_wd;
            bus.grf_pc = bus.p_pc;
        end
    end

    // Set after clear so a same-cycle issue to the popped register stays pending.
    always_comb begin
        w_pending_d = r_pending;
        if (w_pop) begin
            w_pending_d[w_head_a3] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_a3 != 5'd0)) begin
            w_pending_d[bus.iss_a3] = 1'b1;
        end
        w_pending_d[0] = 1'b0;
    end

    // Payload storage needs no reset; validity is carried by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_a3[r_wptr] <= bus.m_a3;
            r_fifo_wd[r_wptr] <= bus.m_wd;
            r_fifo_pc[r_wptr] <= bus.m_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_cnt     <= '0;
            r_starve  <= '0;
            r_pending <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            // Non-empty without a pop means the pipeline took the port iff p_we.
            if (w_pop || w_empty) begin
                r_starve <= '0;
            end else if (bus.p_we && (r_starve != SW'(STARVE_MAX))) begin
                r_starve <= r_starve + SW'(1);
            end
            r_pending <= w_pending_d;
        end
    end
endmodule
